// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I main controller.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP
  } ctrl_state_t;

  typedef enum logic [2:0] {
    CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_ILLEGAL
  } inst_class_t;

endpackage

// File: rtl/inst_classifier.sv
// Combinational opcode decoder: maps inst[6:0] to an instruction class.
module inst_classifier
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0]  opcode_i,
  output inst_class_t class_o
);

  always_comb begin
    class_o = CL_ILLEGAL;
    case (opcode_i)
      OPC_R:      class_o = CL_R;
      OPC_I:      class_o = CL_I;
      OPC_LOAD:   class_o = CL_LOAD;
      OPC_STORE:  class_o = CL_STORE;
      OPC_BRANCH: class_o = CL_BRANCH;
      default:    class_o = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle main control FSM: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with
// memory timeout, illegal-opcode trap and a retired-instruction counter.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst,
  input  logic             mem_ready,
  input  logic             zero,
  input  logic             trap_clr,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_req,
  output logic             Branch,
  output logic             memread,
  output logic             memwrite,
  output logic             mem2reg,
  output logic             alusrc,
  output logic             regwrite,
  output logic [1:0]       aluop,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] instret_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_t       state_q, state_d;
  inst_class_t       class_q, class_d;
  inst_class_t       decodedClass;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic              timeoutCause_q, timeoutCause_d;
  logic [CNT_W-1:0]  retireCnt_q, retireCnt_d;
  logic              retire;
  logic              memExpired;
  logic              classAluSrc;
  logic [1:0]        classAluOp;
  logic              unused_inst_bits;

  // Only the opcode field matters to the controller.
  assign unused_inst_bits = ^inst[31:7];

  inst_classifier u_classifier (
    .opcode_i (inst[6:0]),
    .class_o  (decodedClass)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      class_q        <= CL_R;
      waitCnt_q      <= '0;
      timeoutCause_q <= 1'b0;
      retireCnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      class_q        <= class_d;
      waitCnt_q      <= waitCnt_d;
      timeoutCause_q <= timeoutCause_d;
      retireCnt_q    <= retireCnt_d;
    end
  end

  // Wait counter defaults to zero so it restarts on every entry to FETCH/MEMORY.
  always_comb begin
    state_d        = state_q;
    class_d        = class_q;
    waitCnt_d      = '0;
    timeoutCause_d = timeoutCause_q;
    retire         = 1'b0;
    memExpired     = (waitCnt_q == WAIT_LAST) && !mem_ready;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (mem_ready) begin
          state_d = DECODE;
        end else if (memExpired) begin
          state_d        = TRAP;
          timeoutCause_d = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      DECODE: begin
        class_d = decodedClass;
        if (decodedClass == CL_ILLEGAL) begin
          state_d        = TRAP;
          timeoutCause_d = 1'b0;
        end else begin
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        case (class_q)
          CL_BRANCH: begin
            state_d = FETCH;
            retire  = 1'b1;
          end
          CL_LOAD, CL_STORE: state_d = MEMORY;
          default:           state_d = WRITEBACK;
        endcase
      end
      MEMORY: begin
        if (mem_ready) begin
          state_d = (class_q == CL_STORE) ? FETCH : WRITEBACK;
          retire  = (class_q == CL_STORE);
        end else if (memExpired) begin
          state_d        = TRAP;
          timeoutCause_d = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      WRITEBACK: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      TRAP: begin
        if (trap_clr) begin
          state_d        = IDLE;
          timeoutCause_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    retireCnt_d = retire ? retireCnt_q + CNT_W'(1) : retireCnt_q;
  end

  always_comb begin
    classAluSrc = 1'b0;
    classAluOp  = ALUOP_RTYPE;
    case (class_q)
      CL_I:              begin classAluSrc = 1'b1; classAluOp = ALUOP_ITYPE; end
      CL_LOAD, CL_STORE: begin classAluSrc = 1'b1; classAluOp = ALUOP_ADD;   end
      CL_BRANCH:         begin classAluSrc = 1'b0; classAluOp = ALUOP_SUB;   end
      default:           begin classAluSrc = 1'b0; classAluOp = ALUOP_RTYPE; end
    endcase
  end

  // Moore output decode; WRITEBACK keeps the ALU operands steady for the result.
  always_comb begin
    pc_write = 1'b0;
    ir_write = 1'b0;
    mem_req  = 1'b0;
    Branch   = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    mem2reg  = 1'b0;
    alusrc   = 1'b0;
    regwrite = 1'b0;
    aluop    = ALUOP_ADD;
    illegal  = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req  = 1'b1;
        memread  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      EXECUTE: begin
        alusrc = classAluSrc;
        aluop  = classAluOp;
        if (class_q == CL_BRANCH) begin
          Branch   = 1'b1;
          pc_write = zero;
        end
      end
      MEMORY: begin
        mem_req  = 1'b1;
        alusrc   = 1'b1;
        aluop    = ALUOP_ADD;
        memread  = (class_q == CL_LOAD);
        memwrite = (class_q == CL_STORE);
      end
      WRITEBACK: begin
        regwrite = 1'b1;
        mem2reg  = (class_q == CL_LOAD);
        alusrc   = classAluSrc;
        aluop    = classAluOp;
      end
      TRAP: begin
        illegal = 1'b1;
        timeout = timeoutCause_q;
      end
      default: ;
    endcase
  end

  assign instret_count = retireCnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed and randomized checks of the multi-cycle controller against an
// instruction-level model of cycle counts and per-output activity.
module tb_multicycle_controller;

  localparam int TMO = 4;
  localparam int CW  = 4;

  localparam logic [12:0] V_PCW  = 13'h1000;
  localparam logic [12:0] V_IRW  = 13'h0800;
  localparam logic [12:0] V_REQ  = 13'h0400;
  localparam logic [12:0] V_BR   = 13'h0200;
  localparam logic [12:0] V_MRD  = 13'h0100;
  localparam logic [12:0] V_MWR  = 13'h0080;
  localparam logic [12:0] V_M2R  = 13'h0040;
  localparam logic [12:0] V_ASRC = 13'h0020;
  localparam logic [12:0] V_RW   = 13'h0010;
  localparam logic [12:0] V_SUB  = 13'h0004;
  localparam logic [12:0] V_RTY  = 13'h0008;
  localparam logic [12:0] V_ITY  = 13'h000C;
  localparam logic [12:0] V_ILL  = 13'h0002;
  localparam logic [12:0] V_TO   = 13'h0001;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   inst;
  logic          mem_ready, zero, trap_clr;
  logic          pc_write, ir_write, mem_req, Branch, memread, memwrite;
  logic          mem2reg, alusrc, regwrite, illegal, timeout;
  logic [1:0]    aluop;
  logic [CW-1:0] instret_count;

  int passCount   = 0;
  int totalChecks = 0;
  int modelCount  = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst          (inst),
    .mem_ready     (mem_ready),
    .zero          (zero),
    .trap_clr      (trap_clr),
    .pc_write      (pc_write),
    .ir_write      (ir_write),
    .mem_req       (mem_req),
    .Branch        (Branch),
    .memread       (memread),
    .memwrite      (memwrite),
    .mem2reg       (mem2reg),
    .alusrc        (alusrc),
    .regwrite      (regwrite),
    .aluop         (aluop),
    .illegal       (illegal),
    .timeout       (timeout),
    .instret_count (instret_count)
  );

  function automatic logic [12:0] obsVec();
    return {pc_write, ir_write, mem_req, Branch, memread, memwrite, mem2reg,
            alusrc, regwrite, aluop, illegal, timeout};
  endfunction

  task automatic checkOutput(input string tag, input logic [12:0] exp);
    logic [12:0] obs;
    obs = obsVec();
    totalChecks++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic checkValue(input string tag, input int obs, input int exp);
    totalChecks++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One clock cycle: outputs checked mid-cycle, then advance past the edge.
  task automatic applyStimulus(input string tag, input logic [12:0] exp);
    @(negedge clk);
    checkOutput(tag, exp);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] opcodeFor(input int sel);
    case (sel)
      0:       return 7'b0110011;
      1:       return 7'b0010011;
      2:       return 7'b0000011;
      3:       return 7'b0100011;
      4:       return 7'b1100011;
      default: return 7'b1111111;
    endcase
  endfunction

  // Instruction-level model: sel 0=R 1=I 2=LOAD 3=STORE 4=BRANCH 5=illegal.
  // Only per-output activity totals and the final outcome are predicted.
  task automatic runRandom(input int idx);
    logic [31:0] r;
    logic [6:0]  op;
    logic        z;
    int sel, fd, md, fetchCyc, dec, exe, memCyc, wb, total, memStart;
    bit fetchTO, memTO, trapped;
    int expCnt[13];
    int seen[13];
    sel = $urandom_range(0, 5);
    op  = opcodeFor(sel);
    if (sel == 5) begin
      do op = 7'($urandom); while (op == 7'b0110011 || op == 7'b0010011 ||
        op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100011);
    end
    r  = $urandom;
    fd = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO, TMO + 2) : $urandom_range(0, TMO - 1);
    md = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO, TMO + 2) : $urandom_range(0, TMO - 1);
    z  = 1'($urandom_range(0, 1));

    fetchTO  = (fd >= TMO);
    fetchCyc = fetchTO ? TMO : fd + 1;
    dec      = fetchTO ? 0 : 1;
    exe      = (!fetchTO && sel != 5) ? 1 : 0;
    memTO    = (exe == 1) && (sel == 2 || sel == 3) && (md >= TMO);
    memCyc   = (exe == 1 && (sel == 2 || sel == 3)) ? (memTO ? TMO : md + 1) : 0;
    wb       = (exe == 1 && (sel == 0 || sel == 1 || (sel == 2 && !memTO))) ? 1 : 0;
    trapped  = fetchTO || sel == 5 || memTO;
    total    = fetchCyc + dec + exe + memCyc + wb;
    memStart = fetchCyc + dec + exe;

    foreach (expCnt[b]) begin expCnt[b] = 0; seen[b] = 0; end
    expCnt[11] = fetchTO ? 0 : 1;
    expCnt[12] = expCnt[11] + ((sel == 4 && exe == 1 && z) ? 1 : 0);
    expCnt[10] = fetchCyc + memCyc;
    expCnt[9]  = (sel == 4) ? exe : 0;
    expCnt[8]  = fetchCyc + ((sel == 2) ? memCyc : 0);
    expCnt[7]  = (sel == 3) ? memCyc : 0;
    expCnt[6]  = (sel == 2) ? wb : 0;
    expCnt[5]  = (sel >= 1 && sel <= 3) ? exe + memCyc + wb : 0;
    expCnt[4]  = wb;

    for (int k = 0; k < total; k++) begin
      inst     = {r[31:7], op};
      trap_clr = 1'($urandom_range(0, 1));
      zero     = (k == fetchCyc + dec) ? z : 1'($urandom_range(0, 1));
      if (k < fetchCyc)
        mem_ready = !fetchTO && (k == fd);
      else if (k >= memStart && k < memStart + memCyc)
        mem_ready = !memTO && (k - memStart == md);
      else
        mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      for (int b = 0; b < 13; b++) seen[b] += int'(obsVec() >> b) & 1;
      @(posedge clk);
      #1;
    end
    trap_clr = 1'b0;
    for (int b = 0; b < 13; b++) begin
      if (b == 2 || b == 3) continue;
      checkValue($sformatf("rnd%0d_sel%0d_bit%0d", idx, sel, b), seen[b], expCnt[b]);
    end
    if (!trapped) modelCount++;
    checkValue($sformatf("rnd%0d_instret", idx), int'(instret_count), modelCount % (1 << CW));
    if (trapped) begin
      mem_ready = 1'($urandom_range(0, 1));
      applyStimulus($sformatf("rnd%0d_trap", idx), V_ILL | ((fetchTO || memTO) ? V_TO : 13'h0));
      trap_clr = 1'b1;
      applyStimulus($sformatf("rnd%0d_trapclr", idx), V_ILL | ((fetchTO || memTO) ? V_TO : 13'h0));
      trap_clr = 1'b0;
      applyStimulus($sformatf("rnd%0d_idle", idx), 13'h0);
    end
  endtask

  initial begin
    rst = 1'b1; inst = 32'h0; mem_ready = 1'b0; zero = 1'b0; trap_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", 13'h0);
    checkValue("reset_instret", int'(instret_count), 0);
    rst = 1'b0;
    applyStimulus("idle", 13'h0);

    // addi x1, x0, 5
    inst = 32'h00500093; mem_ready = 1'b1;
    applyStimulus("addi_fetch", V_PCW | V_IRW | V_REQ | V_MRD);
    applyStimulus("addi_decode", 13'h0);
    applyStimulus("addi_exec", V_ASRC | V_ITY);
    applyStimulus("addi_wb", V_ASRC | V_ITY | V_RW);
    checkValue("addi_instret", int'(instret_count), 1);

    // lw with three not-ready memory cycles; ready lands on the last allowed wait
    inst = 32'h0000A103;
    applyStimulus("lw_fetch", V_PCW | V_IRW | V_REQ | V_MRD);
    applyStimulus("lw_decode", 13'h0);
    applyStimulus("lw_exec", V_ASRC);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus($sformatf("lw_mem_wait%0d", i), V_REQ | V_MRD | V_ASRC);
    mem_ready = 1'b1;
    applyStimulus("lw_mem_ready", V_REQ | V_MRD | V_ASRC);
    applyStimulus("lw_wb", V_RW | V_M2R | V_ASRC);
    checkValue("lw_instret", int'(instret_count), 2);

    // sw
    inst = 32'h0020A023;
    applyStimulus("sw_fetch", V_PCW | V_IRW | V_REQ | V_MRD);
    applyStimulus("sw_decode", 13'h0);
    applyStimulus("sw_exec", V_ASRC);
    applyStimulus("sw_mem", V_REQ | V_MWR | V_ASRC);
    checkValue("sw_instret", int'(instret_count), 3);
    mem_ready = 1'b0;
    applyStimulus("sw_back_fetch", V_REQ | V_MRD);

    // beq taken, then not taken
    inst = 32'h00000463; mem_ready = 1'b1; zero = 1'b1;
    applyStimulus("beq1_fetch", V_PCW | V_IRW | V_REQ | V_MRD);
    applyStimulus("beq1_decode", 13'h0);
    applyStimulus("beq1_exec", V_BR | V_SUB | V_PCW);
    checkValue("beq1_instret", int'(instret_count), 4);
    zero = 1'b0;
    applyStimulus("beq0_fetch", V_PCW | V_IRW | V_REQ | V_MRD);
    applyStimulus("beq0_decode", 13'h0);
    applyStimulus("beq0_exec", V_BR | V_SUB);
    checkValue("beq0_instret", int'(instret_count), 5);

    // illegal opcode 0x7F
    inst = 32'h0000007F;
    applyStimulus("ill_fetch", V_PCW | V_IRW | V_REQ | V_MRD);
    applyStimulus("ill_decode", 13'h0);
    applyStimulus("ill_trap", V_ILL);
    trap_clr = 1'b1;
    applyStimulus("ill_trap_clr", V_ILL);
    trap_clr = 1'b0;
    applyStimulus("ill_idle", 13'h0);
    checkValue("ill_instret", int'(instret_count), 5);

    // fetch timeout, then asynchronous reset while trapped
    mem_ready = 1'b0;
    for (int i = 0; i < TMO; i++) applyStimulus($sformatf("to_fetch%0d", i), V_REQ | V_MRD);
    applyStimulus("to_trap", V_ILL | V_TO);
    #3 rst = 1'b1;
    #1;
    checkOutput("async_rst_outputs", 13'h0);
    checkValue("async_rst_instret", int'(instret_count), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus("post_rst_idle", 13'h0);

    modelCount = 0;
    for (int n = 0; n < 40; n++) runRandom(n);

    $display("[TB] %0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule
